// File: rtl/spi_block_tx.sv
// SPI mode-0 block transmitter: buffers upstream blocks in a small FIFO and sends each as one CS-framed, MSB-first word.
// Optional build macro SPI_BLOCK_TX_FRAME_COUNT_EN enables the word counter and frame_done_out pulse.
module spi_block_tx #(
  parameter int REGISTER_SIZE   = 32,
  parameter int NUM_BLOCKS      = 128,
  parameter int DATA_CLK_PERIOD = 100,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic                     chip_data_out,
  output logic                     chip_clk_out,
  output logic                     chip_sel_out,
  output logic                     busy_out,
  output logic                     frame_done_out
);
  localparam int HALF = DATA_CLK_PERIOD / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW   = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(REGISTER_SIZE - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER_HI, XFER_LO, GAP} state_e;

  state_e                   state_q, state_d;
  logic [REGISTER_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [PW:0]              count_q, count_d;
  logic [REGISTER_SIZE-1:0] shift_q, shift_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic                     ready_q, ready_d;
  logic                     cs_q, cs_d, sck_q, sck_d, sdo_q, sdo_d, busy_q, busy_d;
  logic                     push, pop, half_done, last_bit, xfer;

  assign push      = valid_in && ready_q;
  assign half_done = (cnt_q == HALF_LAST);
  assign last_bit  = (bit_q == BIT_LAST);

  // State register and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      ready_q <= 1'b1;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[tail_q] <= block_in;
  end

  // Next-state logic; pop happens only on the transition into SETUP
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:    if (count_q != '0) begin state_d = SETUP; pop = 1'b1; end
      SETUP:   if (half_done) state_d = XFER_HI;
      XFER_HI: if (half_done) state_d = XFER_LO;
      XFER_LO: if (half_done) state_d = last_bit ? GAP : XFER_HI;
      GAP: if (half_done) begin
        if (count_q != '0) begin state_d = SETUP; pop = 1'b1; end
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers and serializer datapath
  always_comb begin
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != DEPTH_C);
    shift_d = shift_q;
    bit_d   = bit_q;
    cnt_d   = '0;
    if (state_q != IDLE && !half_done) cnt_d = cnt_q + CW'(1);
    if (pop) begin
      shift_d = mem_q[head_q];
      bit_d   = '0;
    end else if (state_q == XFER_HI && half_done && !last_bit) begin
      shift_d = {shift_q[REGISTER_SIZE-2:0], 1'b0};
    end else if (state_q == XFER_LO && half_done) begin
      bit_d = last_bit ? '0 : bit_q + BW'(1);
    end
  end

  // Outputs decoded from next state so the pins are registered
  always_comb begin
    xfer   = (state_d == SETUP) || (state_d == XFER_HI) || (state_d == XFER_LO);
    cs_d   = !xfer;
    sck_d  = (state_d == XFER_HI);
    sdo_d  = xfer && shift_d[REGISTER_SIZE-1];
    busy_d = (state_d != IDLE);
  end

  assign ready_out     = ready_q;
  assign chip_sel_out  = cs_q;
  assign chip_clk_out  = sck_q;
  assign chip_data_out = sdo_q;
  assign busy_out      = busy_q;

`ifdef SPI_BLOCK_TX_FRAME_COUNT_EN
  localparam int WW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_BLOCKS - 1);
  logic [WW-1:0] word_q, word_d;
  logic          fd_q, fd_d;

  always_comb begin
    word_d = word_q;
    fd_d   = 1'b0;
    if (state_q == GAP && half_done) begin
      if (word_q == WORD_LAST) begin
        word_d = '0;
        fd_d   = 1'b1;
      end else begin
        word_d = word_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      word_q <= word_d;
      fd_q   <= fd_d;
    end
  end

  assign frame_done_out = fd_q;
`else
  assign frame_done_out = 1'b0;
`endif
endmodule

// File: tb/tb_spi_block_tx.sv
// Directed bench for spi_block_tx: SPI receiver model plus single-word table, back-to-back, FIFO-full, reset and frame sequences.
module tb_spi_block_tx;
  localparam int RS = 32, NB = 4, PER = 4, FD = 4;

  logic          clk_in = 1'b0, rst_in = 1'b1, valid_in = 1'b0;
  logic [RS-1:0] block_in = '0;
  logic          ready_out, chip_data_out, chip_clk_out, chip_sel_out, busy_out, frame_done_out;

  spi_block_tx #(.REGISTER_SIZE(RS), .NUM_BLOCKS(NB), .DATA_CLK_PERIOD(PER), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .block_in(block_in), .valid_in(valid_in),
    .ready_out(ready_out), .chip_data_out(chip_data_out), .chip_clk_out(chip_clk_out),
    .chip_sel_out(chip_sel_out), .busy_out(busy_out), .frame_done_out(frame_done_out));

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Receiver model, sampling 2 time units after each rising system clock edge
  int cyc = 0, nbits = 0, pre = 0, rise_cnt = 0, sck_bad = 0, gap_run = 0, fd_cnt = 0, cs_fall_cnt = 0, busy_fall_cyc = 0;
  bit seen_rise = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, prev_rdy = 1'b1;
  logic [31:0] rsh = '0;
  logic [7:0]  f8 = '0;
  logic [31:0] rxq[$];
  logic [7:0]  f8q[$];
  int preq[$], gapq[$], fallq[$], fdq[$], rdyq[$];

  always begin
    @(posedge clk_in);
    #2;
    cyc++;
    if (!chip_sel_out && prev_cs) begin
      cs_fall_cnt++;
      fallq.push_back(cyc);
      nbits = 0; seen_rise = 0; pre = 0;
      if (gap_run > 0) gapq.push_back(gap_run);
      gap_run = 0;
    end
    if (chip_clk_out && !prev_sck) begin
      rise_cnt++;
      if (!chip_sel_out) begin
        rsh = {rsh[30:0], chip_data_out};
        nbits++;
        if (nbits == 8) f8 = rsh[7:0];
        if (!seen_rise) preq.push_back(pre);
        seen_rise = 1;
      end else sck_bad++;
    end else if (!chip_sel_out && !seen_rise) pre++;
    if (chip_sel_out && !prev_cs) begin
      if (nbits == RS) begin rxq.push_back(rsh); f8q.push_back(f8); end
      nbits = 0;
    end
    if (chip_sel_out && busy_out) gap_run++;
    if (!busy_out) gap_run = 0;
    if (!busy_out && prev_busy) busy_fall_cyc = cyc;
    if (frame_done_out) begin fd_cnt++; fdq.push_back(rxq.size()); end
    if (ready_out && !prev_rdy) rdyq.push_back(cyc);
    prev_sck = chip_clk_out; prev_cs = chip_sel_out; prev_busy = busy_out; prev_rdy = ready_out;
  end

  function automatic logic [31:0] rx_at(input int i);
    return (i < rxq.size()) ? rxq[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Streams words honouring ready_out; reports how many were accepted when ready first dropped
  task automatic push_seq(input logic [31:0] w[$], output int first_low_at);
    int k = 0, guard = 0;
    first_low_at = -1;
    while (k < w.size() && guard < 8000) begin
      @(negedge clk_in);
      guard++;
      if (!ready_out && first_low_at < 0) first_low_at = k;
      block_in = w[k];
      valid_in = 1'b1;
      if (ready_out) k++;
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    if (k < w.size()) chk("push_timeout", k, w.size());
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (busy_out && g < 3000) begin @(negedge clk_in); g++; end
    chk(nm, busy_out, 0);
  endtask

  typedef struct { logic [31:0] din; logic [7:0] exp_f8; logic [31:0] exp_rx; } vec_t;
  vec_t vec[6];

  initial begin
    logic [31:0] q[$];
    int lo, rb, fb, gb, rdb, fdb, cfb, base, rbase;
    vec[0] = '{32'hA5A5_0F0F, 8'hA5, 32'hA5A5_0F0F};
    vec[1] = '{32'h0000_0001, 8'h00, 32'h0000_0001};
    vec[2] = '{32'h8000_0000, 8'h80, 32'h8000_0000};
    vec[3] = '{32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF};
    vec[4] = '{32'h1234_5678, 8'h12, 32'h1234_5678};
    vec[5] = '{32'h0F0F_A5A5, 8'h0F, 32'h0F0F_A5A5};

    // Reset state
    tick(2);
    chk("rst_cs", chip_sel_out, 1);
    chk("rst_sck", chip_clk_out, 0);
    chk("rst_data", chip_data_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_fd", frame_done_out, 0);
    chk("rst_ready", ready_out, 1);
    rst_in = 1'b0;
    tick(2);

    // Single words from the table
    for (int i = 0; i < 6; i++) begin
      rb = rxq.size(); base = preq.size(); fb = rise_cnt;
      q.delete(); q.push_back(vec[i].din);
      push_seq(q, lo);
      chk("lat_cs_hi", chip_sel_out, 1);
      tick(1);
      chk("lat_cs_lo", chip_sel_out, 0);
      wait_idle("single_idle");
      chk("single_rxcnt", rxq.size() - rb, 1);
      chk("single_rx", rx_at(rb), vec[i].exp_rx);
      chk("single_f8", (f8q.size() > rb) ? f8q[rb] : 8'hxx, vec[i].exp_f8);
      chk("single_pre", (preq.size() > base) ? preq[base] : -1, 2);
      chk("single_rises", rise_cnt - fb, RS);
      chk("single_sck_cs_hi", sck_bad, 0);
    end

    // Back-to-back
    tick(3);
    rb = rxq.size(); fb = fallq.size(); gb = gapq.size();
    q.delete(); q.push_back(32'h0000_0001); q.push_back(32'h8000_0000); q.push_back(32'hFFFF_FFFF);
    push_seq(q, lo);
    wait_idle("b2b_idle");
    chk("b2b_rx0", rx_at(rb), 32'h0000_0001);
    chk("b2b_rx1", rx_at(rb + 1), 32'h8000_0000);
    chk("b2b_rx2", rx_at(rb + 2), 32'hFFFF_FFFF);
    chk("b2b_ngap", gapq.size() - gb, 2);
    chk("b2b_gap0", (gapq.size() > gb) ? gapq[gb] : -1, PER / 2);
    chk("b2b_gap1", (gapq.size() > gb + 1) ? gapq[gb + 1] : -1, PER / 2);
    chk("b2b_span", (fallq.size() > fb) ? busy_fall_cyc - fallq[fb] : -1, 3 * 33 * PER);

    // FIFO full
    tick(3);
    rb = rxq.size(); fb = fallq.size(); rdb = rdyq.size();
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(32'hC0DE_0000 + i);
    push_seq(q, lo);
    chk("full_low_after", lo, 5);
    chk("full_rdy_rise_at_pop",
        (rdyq.size() > rdb) ? rdyq[rdb] : -1, (fallq.size() > fb + 1) ? fallq[fb + 1] : -2);
    wait_idle("full_idle");
    chk("full_rxcnt", rxq.size() - rb, 6);
    for (int i = 0; i < 6; i++) chk("full_rx", rx_at(rb + i), 32'hC0DE_0000 + i);

    // Reset mid-word
    tick(3);
    q.delete(); q.push_back(32'h1234_5678); q.push_back(32'hAAAA_0001); q.push_back(32'hAAAA_0002);
    push_seq(q, lo);
    begin
      int g = 0;
      while (nbits < 10 && g < 2000) begin @(negedge clk_in); g++; end
      chk("rst_mid_reach_bit10", nbits, 10);
    end
    rb = rxq.size();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rstmid_cs", chip_sel_out, 1);
    chk("rstmid_sck", chip_clk_out, 0);
    chk("rstmid_data", chip_data_out, 0);
    chk("rstmid_ready", ready_out, 1);
    chk("rstmid_busy", busy_out, 0);
    rst_in = 1'b0;
    cfb = cs_fall_cnt;
    tick(300);
    chk("rstmid_no_cs", cs_fall_cnt - cfb, 0);
    chk("rstmid_no_rx", rxq.size() - rb, 0);
    chk("rstmid_busy_after", busy_out, 0);

    // Frame marking over two frames
    rb = rxq.size(); fdb = fd_cnt; rbase = fdq.size();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(i);
    push_seq(q, lo);
    wait_idle("frame_idle");
    tick(2);
    for (int i = 0; i < 8; i++) chk("frame_rx", rx_at(rb + i), i);
`ifdef SPI_BLOCK_TX_FRAME_COUNT_EN
    chk("frame_pulses", fd_cnt - fdb, 2);
    chk("frame_pulse0_after", (fdq.size() > rbase) ? fdq[rbase] - rb : -1, 4);
    chk("frame_pulse1_after", (fdq.size() > rbase + 1) ? fdq[rbase + 1] - rb : -1, 8);
`else
    chk("frame_pulses", fd_cnt - fdb, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_block_tx.md
# spi_block_tx

Controller-side SPI transmitter that streams multi-block operands (e.g. a 4096-bit ciphertext as 128 × 32-bit blocks) to the tally board's SPI receiver. Accepts blocks from an upstream valid/ready stream into a small FIFO, serializes each block MSB-first as one chip-select-framed word, and marks the end of every NUM_BLOCKS-word frame. Sits on the voter/encryptor side, directly facing the tally board's `spi_rec` instance.

## Interface
- `REGISTER_SIZE`, 32: bits per block/word.
- `NUM_BLOCKS`, 128: words per frame (`N_SQUARED_SIZE/REGISTER_SIZE`).
- `DATA_CLK_PERIOD`, 100: `clk_in` cycles per `chip_clk_out` period; even, ≥ 2.
- `FIFO_DEPTH`, 4: block buffer entries; power of two, ≥ 2.
- `clk_in`  in  1  system clock (100 MHz).
- `rst_in`  in  1  synchronous, active-high reset.
- `block_in`  in  REGISTER_SIZE  block to send.
- `valid_in`  in  1  `block_in` valid; pushed when `valid_in && ready_out`.
- `ready_out`  out  1  FIFO not full.
- `chip_data_out`  out  1  serial data (COPI).
- `chip_clk_out`  out  1  serial clock, idle low.
- `chip_sel_out`  out  1  chip select, active low.
- `busy_out`  out  1  high whenever state ≠ IDLE.
- `frame_done_out`  out  1  one-cycle pulse after last word of a frame.

## Operation
- SPI mode 0: data driven while clock low, receiver samples on rising edge; MSB first.
- HALF = DATA_CLK_PERIOD/2. Half-period counter counts 0..HALF-1.
- FIFO: circular, head/tail pointers plus count. Push when `valid_in && ready_out`; pop when FSM leaves IDLE/GAP into SETUP. Simultaneous push+pop: count unchanged, both succeed (including when full: pop frees slot only next cycle, `ready_out` stays low that cycle). Push while full dropped (never happens under protocol).
- States:
  - IDLE: cs high, clk low, data 0. FIFO non-empty → pop head into shift register, go SETUP.
  - SETUP: cs low, clk low, data = shift[MSB], HALF cycles → TRANSFER_HI.
  - TRANSFER_HI: clk high, HALF cycles → TRANSFER_LO.
  - TRANSFER_LO: clk low; on entry shift left one bit (next bit presented) unless last bit; HALF cycles; bit counter increments; after REGISTER_SIZE-th bit → GAP, else → TRANSFER_HI.
  - GAP: cs high, clk low, data 0, HALF cycles; word counter increments; → SETUP (popping) if FIFO non-empty, else IDLE.
- Word counter 0..NUM_BLOCKS-1; on leaving GAP with counter = NUM_BLOCKS-1, wrap to 0 and pulse `frame_done_out`.
- All outputs registered.

## Timing
- Reset values: `chip_sel_out`=1, `chip_clk_out`=0, `chip_data_out`=0, `ready_out`=1 (after reset cycle), `busy_out`=0, `frame_done_out`=0; FIFO empty, all counters 0.
- Push on cycle t into empty FIFO with FSM IDLE: `chip_sel_out` falls at t+2 (one cycle FIFO write, one cycle pop/state register).
- Per word: HALF (setup) + REGISTER_SIZE·DATA_CLK_PERIOD (bits) + HALF (gap) = (REGISTER_SIZE+1)·DATA_CLK_PERIOD cycles; defaults: 3300 cycles.
- Back-to-back words: cs high for exactly HALF cycles between words.
- `frame_done_out` high exactly the first cycle after GAP of word NUM_BLOCKS-1.
- Reset mid-word: next cycle all outputs at reset values, FIFO flushed, partial word abandoned, word counter 0; receiver sees cs rise and discards.

## Configuration
- `SPI_BLOCK_TX_FRAME_COUNT_EN`: defined → word counter and `frame_done_out` pulse as above. Undefined → no word counter synthesized, `frame_done_out` tied 0; serialization unchanged.

## Test plan
- Single word: push 0xA5A5_0F0F, DATA_CLK_PERIOD=4 → cs low 2 cycles before first rising clock, 32 rising edges sampling bits 1,0,1,0,0,1,0,1,…,1,1,1,1; cs high after; receiver model captures 0xA5A5_0F0F; `busy_out` low after GAP.
- Back-to-back: push 3 words consecutively (0x0000_0001, 0x8000_0000, 0xFFFF_FFFF) → received in order, cs gap exactly HALF cycles, total 3·(33·PERIOD) cycles cs-active span.
- FIFO full: FIFO_DEPTH=4, push 6 words continuously → `ready_out` deasserts after 5th accept (one popped), reasserts on next pop; all 6 received, none lost or duplicated.
- Frame: NUM_BLOCKS=4, push 8 words 0..7 → `frame_done_out` pulses twice, after words 3 and 7; with macro undefined never pulses.
- Reset mid-word: assert `rst_in` at bit 10 of word 0x1234_5678 with 2 words queued → next cycle cs=1, clk=0, data=0, `ready_out`=1, FIFO empty; no further SPI activity.
